cgia_line_shifter: RTL and testbench
====================================

Name: cgia_line_shifter

Overview:
- Consumer end of the CGIA fetcher's line buffer.
- The fetcher, a Wishbone initiator, writes one scanline of 16-bit video words into a double-banked synchronous RAM. This block reads that RAM back and serializes 1bpp pixels, MSB first, at the dot rate.
- At each line start it swaps banks: the shifter reads the freshly filled bank while the fetcher refills the other one.
- It signals end-of-line back to the fetcher/timing logic.

Parameters:
WORDS_PER_LINE, 40, 16-bit words per scanline (40 → 640 px); legal range 2..2**ADDR_W.
ADDR_W, 6, word-index width within one bank.

Ports:
clk_i  input  1  Wishbone SYSCON clock; all logic on rising edge.
reset_i  input  1  synchronous, active-high reset.
start_i  input  1  one-cycle pulse: begin active region of a line.
dot_en_i  input  1  dot-clock enable; one pixel advances per asserted cycle while active.
rd_en_o  output  1  line-buffer read strobe.
rd_adr_o  output  ADDR_W+1  {bank, word index}; the bank bit is the MSB.
rd_dat_i  input  16  line-buffer data, valid the cycle after rd_en_o (1-cycle RAM latency).
bank_o  output  1  bank currently owned by the shifter; the fetcher writes ~bank_o.
pixel_o  output  1  current pixel; 0 whenever active_o=0.
active_o  output  1  high while pixels are being shifted out.
done_o  output  1  one-cycle pulse after the last pixel of a line.

Behaviour:
- Reset (sync, any state, including mid-line): state=IDLE.
  - All outputs are 0, including bank_o.
  - The shift register, prefetch register, word counter and bit counter are cleared.
- States: IDLE, PRIME0, PRIME1, SHIFT.
- IDLE:
  - On start_i=1: toggle bank_o and go to PRIME0.
  - Otherwise hold all outputs at 0.
- PRIME0 (1 cycle):
  - rd_en_o=1, rd_adr_o={bank_o, 0}; go to PRIME1.
- PRIME1 (1 cycle):
  - Capture rd_dat_i (word 0) into the shift register.
  - rd_en_o=1, rd_adr_o={bank_o, 1}; go to SHIFT.
  - active_o rises on this edge.
  - First active cycle = 3 cycles after the cycle in which start_i was sampled.
- SHIFT:
  - The cycle after any read, rd_dat_i is captured into the prefetch register.
  - pixel_o = shift[15].
  - On dot_en_i=1: shift left by 1 and increment the 4-bit bit counter.
  - When the bit counter wraps 15→0 with dot_en_i=1:
    - Load the shift register from the prefetch register and increment the word counter.
    - If word index+2 < WORDS_PER_LINE, issue rd_en_o=1 with that address on the next cycle.
  - No reads are issued beyond WORDS_PER_LINE-1. rd_en_o is 0 except in the cycles defined above.
  - Prefetch depth of one word guarantees no underrun, even with dot_en_i tied high.
- Line end: the dot_en_i that consumes bit 15 of word WORDS_PER_LINE-1 causes, on that edge:
  - active_o=0, pixel_o=0;
  - done_o=1 for exactly the next cycle;
  - state=IDLE.
- Pixel count: exactly WORDS_PER_LINE*16 dot_en_i pulses per line. dot_en_i during IDLE/PRIME is ignored.
- start_i outside IDLE is ignored: no bank toggle, no restart.
- start_i in the same cycle as done_o: accepted, because the state is already IDLE.
- Arithmetic:
  - Word and bit counters wrap modulo their widths and never exceed their range.
  - rd_adr_o index field is zero-extended to ADDR_W.

Test Plan:
- Reset then idle: hold reset_i 2 cycles, start_i=0 → rd_en_o, rd_adr_o, bank_o, pixel_o, active_o and done_o are all 0.
- Basic line (WORDS_PER_LINE=2, dot_en_i=1), RAM bank1 = {0xA5F0, 0x0F3C}, start_i at cycle n:
  - bank_o=1 from n+1; reads adr 0x40 at n+1, 0x41 at n+2; active_o=1 from n+3.
  - pixel_o sequence is 1010010111110000 then 0000111100111100.
  - done_o=1 at n+35 only.
- Slow dot rate, dot_en_i every 3rd cycle, WORDS_PER_LINE=40, random data:
  - 640 pixels match RAM bits MSB-first; exactly 40 reads with addresses 0..39.
  - rd_en_o is never asserted after index 39.
- Bank ping-pong:
  - Three consecutive lines → bank_o 1,0,1; each read address carries the matching bank bit.
  - start_i issued in the done_o cycle starts the next line with no lost cycle.
- start_i during SHIFT: pulse mid-line → bank_o unchanged; the line completes with 640 pixels; a single done_o pulse.
- Reset mid-line: assert reset_i after 100 pixels → next cycle all outputs are 0 and bank_o=0. A following start_i begins a clean line from bank 1, word 0.

Source files
------------

// File: rtl/cgia_line_shifter.sv
// cgia_line_shifter: reads the double-banked line buffer and serializes 1bpp pixels MSB first
module cgia_line_shifter #(
    parameter int WORDS_PER_LINE = 40,
    parameter int ADDR_W = 6
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              start_i,
    input  logic              dot_en_i,
    output logic              rd_en_o,
    output logic [ADDR_W:0]   rd_adr_o,
    input  logic [15:0]       rd_dat_i,
    output logic              bank_o,
    output logic              pixel_o,
    output logic              active_o,
    output logic              done_o
);
    typedef enum logic [1:0] {IDLE, PRIME0, PRIME1, SHIFT} state_t;
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(WORDS_PER_LINE - 1);
    localparam logic [ADDR_W:0] WPL = (ADDR_W + 1)'(WORDS_PER_LINE);
    state_t state, state_nxt;
    logic [15:0] shift, pre;
    logic [ADDR_W-1:0] wcnt, rd_idx;
    logic [ADDR_W:0] nxt2;
    logic [3:0] bcnt;
    logic rd_req, rd_pend, bank, done, wrap, last;
    // state register
    always_ff @(posedge clk_i) begin
        if (reset_i) state <= IDLE;
        else state <= state_nxt;
    end
    // next state, read strobe/address and pixel outputs
    always_comb begin
        wrap = state == SHIFT && dot_en_i && bcnt == 4'hF;
        last = wrap && wcnt == LAST;
        nxt2 = {1'b0, wcnt} + (ADDR_W + 1)'(2);
        state_nxt = (state == IDLE && start_i) ? PRIME0 :
                    (state == PRIME0) ? PRIME1 :
                    (state == PRIME1) ? SHIFT :
                    last ? IDLE : state;
        rd_en_o = state == PRIME0 || state == PRIME1 || rd_req;
        rd_adr_o = rd_en_o ? {bank, (state == PRIME0) ? ADDR_W'(0) :
                                    (state == PRIME1) ? ADDR_W'(1) : rd_idx} : '0;
        active_o = state == SHIFT;
        pixel_o = active_o & shift[15];
        bank_o = bank;
        done_o = done;
    end
    // bank toggle, shift/prefetch registers and word/bit counters
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            shift <= '0;
            pre <= '0;
            wcnt <= '0;
            rd_idx <= '0;
            bcnt <= '0;
            rd_req <= 1'b0;
            rd_pend <= 1'b0;
            bank <= 1'b0;
            done <= 1'b0;
        end else begin
            done <= last;
            rd_pend <= rd_en_o;
            rd_req <= wrap && nxt2 < WPL;
            rd_idx <= nxt2[ADDR_W-1:0];
            if (state == IDLE && start_i) begin
                bank <= ~bank;
                wcnt <= '0;
                bcnt <= '0;
            end
            if (state == PRIME1) shift <= rd_dat_i;
            if (state == SHIFT && rd_pend) pre <= rd_dat_i;
            if (state == SHIFT && dot_en_i) begin
                bcnt <= bcnt + 4'd1;
                shift <= (bcnt == 4'hF) ? pre : {shift[14:0], 1'b0};
                if (bcnt == 4'hF) wcnt <= wcnt + ADDR_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_cgia_line_shifter.sv
// tb_cgia_line_shifter: scoreboard bench for a 2-word and a 40-word line shifter
module tb_cgia_line_shifter;
    logic clk = 0;
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;
    logic reset = 1, st2 = 0, dot2 = 0, st40 = 0, dot40 = 0;
    logic rd2, bank2, pix2, act2, done2, rd40, bank40, pix40, act40, done40;
    logic [6:0] adr2, adr40;
    logic [15:0] dat2, dat40;
    logic [15:0] mem2 [0:127];
    logic [15:0] mem40 [0:127];
    cgia_line_shifter #(.WORDS_PER_LINE(2), .ADDR_W(6)) u2 (
        .clk_i(clk), .reset_i(reset), .start_i(st2), .dot_en_i(dot2), .rd_en_o(rd2),
        .rd_adr_o(adr2), .rd_dat_i(dat2), .bank_o(bank2), .pixel_o(pix2),
        .active_o(act2), .done_o(done2));
    cgia_line_shifter #(.WORDS_PER_LINE(40), .ADDR_W(6)) u40 (
        .clk_i(clk), .reset_i(reset), .start_i(st40), .dot_en_i(dot40), .rd_en_o(rd40),
        .rd_adr_o(adr40), .rd_dat_i(dat40), .bank_o(bank40), .pixel_o(pix40),
        .active_o(act40), .done_o(done40));
    always @(posedge clk) begin
        if (rd2) dat2 <= mem2[adr2];
        if (rd40) dat40 <= mem40[adr40];
    end
    int checks = 0, failures = 0;
    bit pq2[$], pq40[$];
    logic [6:0] aq2[$], aq40[$];
    int rq2[$], dq2[$], rq40[$];
    logic bq40[$];
    int dexp40 = 0;
    logic eb40 = 0;
    logic act2_d = 0, act40_d = 0;
    int per40 = 1, dcnt = 0;
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask
    always @(negedge clk) begin
        if (act2 && dot2) begin
            if (pq2.size() > 0) chk("pix2", pix2, pq2.pop_front());
            else chk("pix2_extra", 1, 0);
        end
        if (rd2) begin
            if (aq2.size() > 0) chk("adr2", adr2, aq2.pop_front());
            else chk("rd2_extra", 1, 0);
        end
        if (act2 && !act2_d) begin
            if (rq2.size() > 0) chk("rise2_cycle", cyc, rq2.pop_front());
            else chk("rise2_extra", 1, 0);
            chk("bank2", bank2, 1);
        end
        if (done2) begin
            if (dq2.size() > 0) chk("done2_cycle", cyc, dq2.pop_front());
            else chk("done2_extra", 1, 0);
        end
        act2_d = act2;
    end
    always @(negedge clk) begin
        if (act40 && dot40) begin
            if (pq40.size() > 0) chk("pix40", pix40, pq40.pop_front());
            else chk("pix40_extra", 1, 0);
        end
        if (rd40) begin
            if (aq40.size() > 0) chk("adr40", adr40, aq40.pop_front());
            else chk("rd40_extra", 1, 0);
        end
        if (act40 && !act40_d) begin
            if (rq40.size() > 0) chk("rise40_cycle", cyc, rq40.pop_front());
            else chk("rise40_extra", 1, 0);
        end
        if (done40) begin
            chk("done40_expected", dexp40 > 0, 1);
            if (dexp40 > 0) begin
                dexp40--;
                chk("done40_bank", bank40, bq40.pop_front());
            end
        end
        act40_d = act40;
    end
    initial forever begin
        @(posedge clk);
        #1;
        dcnt++;
        dot40 = (dcnt % per40) == 0;
    end
    initial begin
        #2000000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end
    task automatic start_line40();
        logic [15:0] w;
        eb40 = ~eb40;
        for (int i = 0; i < 40; i++) begin
            w = 16'($urandom);
            mem40[{eb40, 6'(i)}] = w;
            aq40.push_back({eb40, 6'(i)});
            for (int b = 15; b >= 0; b--) pq40.push_back(w[b]);
        end
        rq40.push_back(cyc + 3);
        bq40.push_back(eb40);
        dexp40++;
        st40 = 1;
        @(posedge clk);
        #1;
        st40 = 0;
    endtask
    task automatic wait40(input int lim);
        int n = 0;
        while ((pq40.size() > 0 || dexp40 > 0) && n < lim) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("line40_timeout", n < lim, 1);
        chk("line40_reads_left", aq40.size(), 0);
    endtask
    task automatic wait_done40();
        int n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!done40 && n < 3000);
        chk("done40_timeout", done40, 1);
    endtask
    initial begin
        logic [15:0] w0, w1;
        int n, lim;
        repeat (2) @(posedge clk);
        #1;
        reset = 0;
        @(negedge clk);
        chk("rst_rd2", rd2, 0); chk("rst_adr2", adr2, 0); chk("rst_bank2", bank2, 0);
        chk("rst_pix2", pix2, 0); chk("rst_act2", act2, 0); chk("rst_done2", done2, 0);
        chk("rst_rd40", rd40, 0); chk("rst_adr40", adr40, 0); chk("rst_bank40", bank40, 0);
        chk("rst_pix40", pix40, 0); chk("rst_act40", act40, 0); chk("rst_done40", done40, 0);
        @(posedge clk);
        #1;
        w0 = 16'hA5F0;
        w1 = 16'h0F3C;
        mem2[64] = w0;
        mem2[65] = w1;
        dot2 = 1;
        repeat (3) @(posedge clk);
        #1;
        for (int b = 15; b >= 0; b--) pq2.push_back(w0[b]);
        for (int b = 15; b >= 0; b--) pq2.push_back(w1[b]);
        aq2.push_back(7'h40);
        aq2.push_back(7'h41);
        rq2.push_back(cyc + 3);
        dq2.push_back(cyc + 35);
        st2 = 1;
        @(posedge clk);
        #1;
        st2 = 0;
        repeat (45) @(posedge clk);
        #1;
        dot2 = 0;
        chk("line2_pix_left", pq2.size(), 0);
        chk("line2_done_left", dq2.size(), 0);
        chk("line2_reads_left", aq2.size(), 0);
        per40 = 1;
        start_line40();
        repeat (2) begin
            wait_done40();
            start_line40();
        end
        wait40(3000);
        per40 = 3;
        start_line40();
        wait40(3000);
        per40 = 2;
        start_line40();
        n = 0;
        while (pq40.size() > 320 && n < 2000) begin @(posedge clk); #1; n++; end
        chk("midstart_reach", n < 2000, 1);
        st40 = 1;
        @(posedge clk);
        #1;
        st40 = 0;
        wait40(3000);
        repeat (10) @(posedge clk);
        #1;
        per40 = 1;
        start_line40();
        lim = 0;
        while (pq40.size() > 540 && lim < 2000) begin @(posedge clk); #1; lim++; end
        chk("midreset_reach", lim < 2000, 1);
        reset = 1;
        @(posedge clk);
        #1;
        reset = 0;
        pq40.delete(); aq40.delete(); rq40.delete(); bq40.delete();
        dexp40 = 0;
        eb40 = 0;
        @(negedge clk);
        chk("mrst_rd40", rd40, 0); chk("mrst_adr40", adr40, 0); chk("mrst_bank40", bank40, 0);
        chk("mrst_pix40", pix40, 0); chk("mrst_act40", act40, 0); chk("mrst_done40", done40, 0);
        @(posedge clk);
        #1;
        start_line40();
        wait40(3000);
        repeat (20) @(posedge clk);
        #1;
        chk("final_bank40", bank40, 1);
        chk("final_rise_left", rq40.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
